wheel_cmd_scheduler: RTL and testbench
======================================

# wheel_cmd_scheduler

Sequences the signed 8-bit wheel commands driven into the two PWM converters (left/right drive wheels). Accepts target commands from the navigation logic over a valid/ready handshake, buffers one pending command, and applies it at PWM frame boundaries with slew-rate limiting. Generates the shared 1 MHz tick enable and a watchdog that ramps both wheels to stop if commands cease.

## Interface
Parameters:
- TICK_DIV, 65: clk cycles per one_MHz_enable pulse (65 MHz system clock).
- FRAME_TICKS, 20000: 1 MHz ticks per update frame (20 ms, one servo PWM period).
- STEP, 8: max per-frame change of each output command (unsigned, 1..127).
- WATCHDOG_FRAMES, 25: frames without an accepted command before timeout.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_valid  in  1  new target pair offered.
- cmd_left  in  8  signed left target.
- cmd_right  in  8  signed right target.
- cmd_ready  out  1  pending buffer empty; accept when cmd_valid & cmd_ready.
- one_MHz_enable  out  1  one-clk pulse every TICK_DIV clks.
- frame_strobe  out  1  one-clk pulse at each frame boundary.
- left_cmd  out  8  signed command to left pwm_converter wheel_cmd.
- right_cmd  out  8  signed command to right pwm_converter wheel_cmd.
- timeout  out  1  watchdog expired; targets forced to 0.

## Operation
- Reset values: cmd_ready=1, one_MHz_enable=0, frame_strobe=0, left_cmd=right_cmd=0, timeout=0; tick/frame/watchdog counters 0; pending empty; targets 0; state RUN.
- Tick divider: counts 0..TICK_DIV-1, wraps; one_MHz_enable registered high for the cycle after count reaches TICK_DIV-1.
- Frame counter: advances on each tick, 0..FRAME_TICKS-1, wraps; frame boundary = tick with count FRAME_TICKS-1.
- Accept: on cmd_valid & cmd_ready, inputs stored in pending; -128 clamped to -127 per channel; pending_full set, cmd_ready=0 next cycle.
- At frame boundary: if pending_full, pending → targets, pending cleared (cmd_ready=1 next cycle). Accept in the same cycle as a boundary with pending empty loads pending only; it applies at the following frame.
- Output update at every frame boundary, per channel: diff = target − out in 9-bit signed; |diff| ≤ STEP → out = target; else out = out ± STEP toward target. Never overshoots; result always within −127..127.
- State machine:
  - RUN: watchdog counter +1 per frame boundary, cleared on accept. Reaching WATCHDOG_FRAMES → TIMEOUT.
  - TIMEOUT: timeout=1; targets forced to 0, pending discarded; outputs slew to 0. An accept → RUN next cycle, timeout=0, watchdog cleared; command applies at next frame boundary.
- Simultaneous accept and watchdog expiry: accept wins, stay RUN.
- Reset mid-operation: all outputs to reset values asynchronously, no ramp-down.

## Timing
- one_MHz_enable, frame_strobe, left_cmd, right_cmd registered; updated on the same clk edge (frame_strobe high in the first cycle new commands are visible).
- Accept → cmd_ready low: 1 cycle. Accept → first output change: next frame boundary (up to one frame + 1 clk).
- Full-scale reversal (−127 → 127): ceil(254/STEP) frames.

## Configuration
- WHEEL_SLEW_EN defined: STEP slew limiting as above.
- Not defined: outputs take the target value directly at the frame boundary; STEP ignored; timeout zeroes outputs at the next boundary.

## Test plan
Bench parameters: TICK_DIV=4, FRAME_TICKS=10, STEP=8, WATCHDOG_FRAMES=8, WHEEL_SLEW_EN defined.
- Release reset, idle → all outputs 0, cmd_ready=1, one_MHz_enable every 4th clk, frame_strobe every 40 clks.
- Send (40, −40) → outputs 8/−8, 16/−16, … reach 40/−40 on 5th frame strobe, then hold.
- Send (−128, 5) → left ramps to −127 (clamp), right settles at 5 in one frame.
- Two back-to-back commands (20,20) then (60,60) → second stalls with cmd_ready=0 until first frame strobe, accepted after; final outputs 60/60.
- Stop commanding at outputs 40/40 → timeout=1 at 8th frame; outputs 32, 24, … 0; new command clears timeout next cycle.
- Assert reset at outputs 24/24 mid-ramp → outputs 0 immediately, cmd_ready=1, timeout=0.

Source files
------------

// File: rtl/wheel_cmd_scheduler.sv
// wheel_cmd_scheduler
//   Sequences the signed 8-bit wheel commands for the left/right PWM
//   converters. It accepts target pairs over a valid/ready handshake and
//   buffers one pending pair. Pending targets are applied at PWM frame
//   boundaries. The block also generates the shared 1 MHz tick enable and
//   runs a command watchdog.
//
//   Optional feature macro: WHEEL_SLEW_EN
//     defined   : each output moves at most STEP per frame toward its target
//     undefined : outputs take the target directly at the frame boundary
//
// Ports
//   clk            in   system clock, all state on rising edge
//   reset          in   asynchronous active-high reset
//   cmd_valid      in   new target pair offered
//   cmd_left       in   signed left target
//   cmd_right      in   signed right target
//   cmd_ready      out  pending buffer empty (accept = cmd_valid & cmd_ready)
//   one_MHz_enable out  one-clk pulse every TICK_DIV clocks
//   frame_strobe   out  one-clk pulse, first cycle new outputs are visible
//   left_cmd       out  signed command to left pwm_converter
//   right_cmd      out  signed command to right pwm_converter
//   timeout        out  watchdog expired, targets forced to zero
module wheel_cmd_scheduler #(
  parameter int unsigned TICK_DIV        = 65,
  parameter int unsigned FRAME_TICKS     = 20000,
  parameter int unsigned STEP            = 8,
  parameter int unsigned WATCHDOG_FRAMES = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_left,
  input  logic [7:0] cmd_right,
  output logic       cmd_ready,
  output logic       one_MHz_enable,
  output logic       frame_strobe,
  output logic [7:0] left_cmd,
  output logic [7:0] right_cmd,
  output logic       timeout
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned WW = (WATCHDOG_FRAMES > 1) ? $clog2(WATCHDOG_FRAMES) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
  localparam logic [WW-1:0] WD_LAST    = WW'(WATCHDOG_FRAMES - 1);

  typedef enum logic {
    ST_RUN,
    ST_TIMEOUT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          tick_en_q, tick_en_d;
  logic          strobe_q, strobe_d;
  logic          pend_full_q, pend_full_d;
  logic [7:0]    pend_l_q, pend_l_d;
  logic [7:0]    pend_r_q, pend_r_d;
  logic [7:0]    tgt_l_q, tgt_l_d;
  logic [7:0]    tgt_r_q, tgt_r_d;
  logic [7:0]    out_l_q, out_l_d;
  logic [7:0]    out_r_q, out_r_d;

  logic          tick;
  logic          boundary;
  logic          accept;
  logic [7:0]    eff_l;
  logic [7:0]    eff_r;

  // -128 has no positive counterpart, so it is folded onto -127.
  function automatic logic [7:0] clamp_cmd(input logic [7:0] v);
    clamp_cmd = (v == 8'h80) ? 8'h81 : v;
  endfunction

`ifdef WHEEL_SLEW_EN
  localparam logic signed [8:0] STEP_S = 9'(STEP);
  localparam logic [7:0]        STEP_U = 8'(STEP);

  // The difference is taken in 9 bits so that -127 -> 127 does not wrap.
  // When |diff| <= STEP the target is taken exactly, so the output never
  // overshoots and stays inside the target range.
  function automatic logic [7:0] slew_to(input logic [7:0] tgt,
                                         input logic [7:0] cur);
    logic signed [8:0] diff;
    diff = $signed({tgt[7], tgt}) - $signed({cur[7], cur});
    if (diff > STEP_S) begin
      slew_to = cur + STEP_U;
    end else if (diff < -STEP_S) begin
      slew_to = cur - STEP_U;
    end else begin
      slew_to = tgt;
    end
  endfunction
`endif

  always_comb begin
    tick     = (tick_cnt_q == TICK_LAST);
    boundary = tick && (frame_cnt_q == FRAME_LAST);
    accept   = cmd_valid && !pend_full_q;

    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
    frame_cnt_d = frame_cnt_q;
    if (tick) begin
      frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + FW'(1);
    end
    tick_en_d = tick;
    strobe_d  = boundary;

    state_d     = state_q;
    wd_d        = wd_q;
    pend_full_d = pend_full_q;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    tgt_l_d     = tgt_l_q;
    tgt_r_d     = tgt_r_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;

    // A pending pair promoted at this boundary already drives this
    // boundary's output step.
    eff_l = pend_full_q ? pend_l_q : tgt_l_q;
    eff_r = pend_full_q ? pend_r_q : tgt_r_q;

    if (boundary) begin
      if (pend_full_q) begin
        tgt_l_d     = pend_l_q;
        tgt_r_d     = pend_r_q;
        pend_full_d = 1'b0;
      end
`ifdef WHEEL_SLEW_EN
      out_l_d = slew_to(eff_l, out_l_q);
      out_r_d = slew_to(eff_r, out_r_q);
`else
      out_l_d = eff_l;
      out_r_d = eff_r;
`endif
    end

    // Accept only happens with pending empty, so it never collides with
    // the pending clear above.
    if (accept) begin
      pend_l_d    = clamp_cmd(cmd_left);
      pend_r_d    = clamp_cmd(cmd_right);
      pend_full_d = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          wd_d = '0;
        end else if (boundary) begin
          if (wd_q == WD_LAST) begin
            state_d     = ST_TIMEOUT;
            wd_d        = '0;
            tgt_l_d     = '0;
            tgt_r_d     = '0;
            pend_full_d = 1'b0;
          end else begin
            wd_d = wd_q + WW'(1);
          end
        end
      end
      ST_TIMEOUT: begin
        tgt_l_d = '0;
        tgt_r_d = '0;
        wd_d    = '0;
        if (accept) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      tick_cnt_q  <= '0;
      frame_cnt_q <= '0;
      wd_q        <= '0;
      tick_en_q   <= 1'b0;
      strobe_q    <= 1'b0;
      pend_full_q <= 1'b0;
      pend_l_q    <= '0;
      pend_r_q    <= '0;
      tgt_l_q     <= '0;
      tgt_r_q     <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      wd_q        <= wd_d;
      tick_en_q   <= tick_en_d;
      strobe_q    <= strobe_d;
      pend_full_q <= pend_full_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      tgt_l_q     <= tgt_l_d;
      tgt_r_q     <= tgt_r_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
    end
  end

  assign cmd_ready      = !pend_full_q;
  assign one_MHz_enable = tick_en_q;
  assign frame_strobe   = strobe_q;
  assign left_cmd       = out_l_q;
  assign right_cmd      = out_r_q;
  assign timeout        = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_wheel_cmd_scheduler.sv
module tb_wheel_cmd_scheduler;

  localparam int STEP_TB = 8;
`ifdef WHEEL_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_left = '0;
  logic [7:0] cmd_right = '0;
  logic       cmd_ready;
  logic       one_MHz_enable;
  logic       frame_strobe;
  logic [7:0] left_cmd;
  logic [7:0] right_cmd;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  wheel_cmd_scheduler #(
    .TICK_DIV(4),
    .FRAME_TICKS(10),
    .STEP(8),
    .WATCHDOG_FRAMES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_left(cmd_left),
    .cmd_right(cmd_right),
    .cmd_ready(cmd_ready),
    .one_MHz_enable(one_MHz_enable),
    .frame_strobe(frame_strobe),
    .left_cmd(left_cmd),
    .right_cmd(right_cmd),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Output after k frames starting at 'from' heading to 'to'.
  function automatic int ramp(input int from, input int to, input int k);
    int d;
    if (!SLEW) return to;
    d = to - from;
    if (d >= 0) return (k * STEP_TB >= d) ? to : from + k * STEP_TB;
    return (k * STEP_TB >= -d) ? to : from - k * STEP_TB;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_strobe && n < 100);
    check(tag, int'(frame_strobe), 1);
  endtask

  task automatic send(input int l, input int r);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_left  = 8'(l);
    cmd_right = 8'(r);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("accept_ready_low", int'(cmd_ready), 0);
  endtask

  initial begin
    int r1;
    int stall_bad;
    int n;

    // Reset state
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_en", int'(one_MHz_enable), 0);
    check("rst_strobe", int'(frame_strobe), 0);
    check("rst_left", $signed(left_cmd), 0);
    check("rst_right", $signed(right_cmd), 0);
    check("rst_timeout", int'(timeout), 0);
    @(negedge clk);
    reset = 1'b0;

    // Idle: tick every 4th clk, strobe every 40th clk
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      check("tick_en", int'(one_MHz_enable), (i % 4 == 0) ? 1 : 0);
      check("frame_strobe", int'(frame_strobe), (i % 40 == 0) ? 1 : 0);
    end
    check("idle_left", $signed(left_cmd), 0);
    check("idle_right", $signed(right_cmd), 0);
    check("idle_ready", int'(cmd_ready), 1);

    // Ramp to (40,-40), then hold
    send(40, -40);
    for (int k = 1; k <= 6; k++) begin
      wait_strobe("b_strobe");
      check("b_left", $signed(left_cmd), ramp(0, 40, k));
      check("b_right", $signed(right_cmd), ramp(0, -40, k));
    end
    check("b_timeout", int'(timeout), 0);

    // Back-to-back commands: second stalls until the first frame strobe
    do_reset();
    send(20, 20);
    cmd_valid = 1'b1;
    cmd_left  = 8'd60;
    cmd_right = 8'd60;
    stall_bad = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!frame_strobe && cmd_ready) stall_bad++;
    end while (!frame_strobe && n < 100);
    check("c_stall_ready", stall_bad, 0);
    check("c_strobe", int'(frame_strobe), 1);
    check("c_ready_after", int'(cmd_ready), 1);
    r1 = ramp(0, 20, 1);
    check("c_left1", $signed(left_cmd), r1);
    check("c_right1", $signed(right_cmd), r1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("c_second_accepted", int'(cmd_ready), 0);
    for (int j = 1; j <= 7; j++) begin
      wait_strobe("c_strobe2");
      check("c_left2", $signed(left_cmd), ramp(r1, 60, j));
      check("c_right2", $signed(right_cmd), ramp(r1, 60, j));
    end
    check("c_final_left", $signed(left_cmd), 60);

    // Watchdog expiry and recovery
    do_reset();
    send(40, 40);
    for (int k = 1; k <= 8; k++) begin
      wait_strobe("d_strobe");
      check("d_left", $signed(left_cmd), ramp(0, 40, k));
      check("d_timeout", int'(timeout), (k == 8) ? 1 : 0);
    end
    for (int j = 1; j <= 5; j++) begin
      wait_strobe("d_strobe_to");
      check("d_to_left", $signed(left_cmd), ramp(40, 0, j));
      check("d_to_right", $signed(right_cmd), ramp(40, 0, j));
      check("d_to_flag", int'(timeout), 1);
    end
    check("d_to_ready", int'(cmd_ready), 1);
    send(10, 10);
    check("d_timeout_clear", int'(timeout), 0);
    for (int j = 1; j <= 2; j++) begin
      wait_strobe("d_strobe_rec");
      check("d_rec_left", $signed(left_cmd), ramp(0, 10, j));
    end

    // Reset mid-ramp with a pending command
    do_reset();
    send(40, 40);
    for (int k = 1; k <= 3; k++) begin
      wait_strobe("e_strobe");
      check("e_left", $signed(left_cmd), ramp(0, 40, k));
    end
    send(40, 40);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("e_rst_left", $signed(left_cmd), 0);
    check("e_rst_right", $signed(right_cmd), 0);
    check("e_rst_ready", int'(cmd_ready), 1);
    check("e_rst_timeout", int'(timeout), 0);
    check("e_rst_strobe", int'(frame_strobe), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_strobe("e_strobe_post");
    check("e_post_left", $signed(left_cmd), 0);
    check("e_post_right", $signed(right_cmd), 0);

    // -128 clamps to -127; small step settles in one frame
    do_reset();
    send(-128, 5);
    for (int k = 1; k <= 17; k++) begin
      wait_strobe("f_strobe");
      check("f_left", $signed(left_cmd), ramp(0, -127, k));
      check("f_right", $signed(right_cmd), ramp(0, 5, k));
      if (k % 4 == 0) send(-128, 5);
    end
    check("f_timeout", int'(timeout), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
